// File: rtl/rsa_mont_exp_param_pkg.sv
// rsa_mont_exp_param_pkg: shared width default and FSM state type for the RSA exponentiator
package rsa_mont_exp_param_pkg;
    localparam int MOD_WIDTH = 256;
    typedef enum logic [2:0] {IDLE, CHECK, PACK, MUL, SQR, DONE} mont_exp_state_e;
endpackage

// File: rtl/montgomery_param.sv
// montgomery_param: bit-serial radix-2 Montgomery product a*b*2^-WIDTH mod n
module montgomery_param #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] n_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] res_o
);
    localparam int CW = $clog2(WIDTH);
    logic busy_q, done_q;
    logic [CW-1:0] cnt_q;
    logic [WIDTH-1:0] a_q, b_q, n_q;
    logic [WIDTH:0] t_q;
    logic [WIDTH+1:0] sum, sum2;
    assign ready_o = !busy_q && !done_q;
    assign valid_o = done_q;
    assign res_o = t_q >= {1'b0, n_q} ? WIDTH'(t_q - {1'b0, n_q}) : t_q[WIDTH-1:0];
    // One Montgomery step: add a_i*b, add n if odd so the halving is exact; t stays below 2n
    always_comb begin
        sum = {1'b0, t_q} + (a_q[0] ? {2'b0, b_q} : '0);
        sum2 = sum + (sum[0] ? {2'b0, n_q} : '0);
    end
    // Operand capture, WIDTH iterations, then hold the result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q <= '0;
            a_q <= '0;
            b_q <= '0;
            n_q <= '0;
            t_q <= '0;
        end else begin
            if (valid_i && ready_o) begin
                a_q <= a_i;
                b_q <= b_i;
                n_q <= n_i;
                t_q <= '0;
                cnt_q <= '0;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                t_q <= (WIDTH+1)'(sum2 >> 1);
                a_q <= a_q >> 1;
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
            if (done_q && ready_i) done_q <= 1'b0;
        end
    end
endmodule

// File: rtl/rsa_mont_exp_param.sv
// rsa_mont_exp_param: msg^key mod N by right-to-left binary exponentiation over a Montgomery multiplier
module rsa_mont_exp_param
    import rsa_mont_exp_param_pkg::*;
#(
    parameter int WIDTH  = MOD_WIDTH,
    parameter int KLEN_W = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [WIDTH-1:0]  i_base,
    input  logic [WIDTH-1:0]  i_msg,
    input  logic [WIDTH-1:0]  i_key,
    input  logic [KLEN_W-1:0] i_key_len,
    input  logic [WIDTH-1:0]  i_modulus,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [WIDTH-1:0]  o_out,
    output logic              o_err,
    output logic [KLEN_W:0]   o_nops
);
    mont_exp_state_e state_q, state_d, nxt;
    logic [WIDTH-1:0] base_q, base_d, msg_q, msg_d, key_q, key_d, n_q, n_d;
    logic [WIDTH-1:0] s_q, s_d, m_q, m_d, out_q, out_d, ksh;
    logic [KLEN_W-1:0] klen_q, klen_d, idx_q, idx_d, nidx, last_idx;
    logic [KLEN_W:0] nops_q, nops_d;
    logic err_q, err_d, busy_q, busy_d;
    logic mm_valid, mm_ready, mm_o_valid;
    logic [WIDTH-1:0] mm_a, mm_b, mm_res;
    assign i_ready = state_q == IDLE;
    assign o_valid = state_q == DONE;
    assign o_out = out_q;
    assign o_err = err_q;
    assign o_nops = nops_q;
    montgomery_param #(.WIDTH(WIDTH)) u_mont (
        .clk(clk),
        .rst(rst),
        .valid_i(mm_valid),
        .ready_o(mm_ready),
        .a_i(mm_a),
        .b_i(mm_b),
        .n_i(n_q),
        .valid_o(mm_o_valid),
        .ready_i(1'b1),
        .res_o(mm_res)
    );
    // Sequencer: s holds msg^(2^idx) in Montgomery form, m accumulates the result in normal form
    always_comb begin
        state_d = state_q;
        base_d = base_q;
        msg_d = msg_q;
        key_d = key_q;
        n_d = n_q;
        klen_d = klen_q;
        s_d = s_q;
        m_d = m_q;
        out_d = out_q;
        idx_d = idx_q;
        nops_d = nops_q;
        err_d = err_q;
        busy_d = busy_q;
        mm_valid = (state_q == PACK || state_q == MUL || state_q == SQR) && !busy_q;
        mm_a = state_q == PACK ? base_q : s_q;
        mm_b = state_q == PACK ? msg_q : (state_q == MUL ? m_q : s_q);
        last_idx = klen_q - KLEN_W'(1);
        nidx = state_q == PACK ? '0 : idx_q + KLEN_W'(1);
        ksh = key_q >> nidx;
        nxt = ksh[0] ? MUL : (nidx == last_idx ? DONE : SQR);
        case (state_q)
            IDLE: if (i_valid) begin
                base_d = i_base;
                msg_d = i_msg;
                key_d = i_key;
                n_d = i_modulus;
                klen_d = i_key_len;
                out_d = '0;
                err_d = 1'b0;
                nops_d = '0;
                state_d = CHECK;
            end
            CHECK: if (!n_q[0] || klen_q > KLEN_W'(WIDTH)) begin
                err_d = 1'b1;
                out_d = '0;
                state_d = DONE;
            end else if (klen_q == '0) begin
                out_d = WIDTH'(1);
                state_d = DONE;
            end else begin
                m_d = WIDTH'(1);
                idx_d = '0;
                busy_d = 1'b0;
                state_d = PACK;
            end
            PACK, MUL, SQR: begin
                if (mm_valid && mm_ready) begin
                    busy_d = 1'b1;
                    nops_d = nops_q + (KLEN_W+1)'(1);
                end
                if (busy_q && mm_o_valid) begin
                    busy_d = 1'b0;
                    out_d = state_q == MUL ? mm_res : m_q;
                    if (state_q == MUL) begin
                        m_d = mm_res;
                        state_d = idx_q == last_idx ? DONE : SQR;
                    end else begin
                        s_d = mm_res;
                        state_d = nxt;
                    end
                    if (state_q == SQR) idx_d = nidx;
                end
            end
            DONE: if (o_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q <= '0;
            msg_q <= '0;
            key_q <= '0;
            n_q <= '0;
            klen_q <= '0;
            s_q <= '0;
            m_q <= '0;
            out_q <= '0;
            idx_q <= '0;
            nops_q <= '0;
            err_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q <= base_d;
            msg_q <= msg_d;
            key_q <= key_d;
            n_q <= n_d;
            klen_q <= klen_d;
            s_q <= s_d;
            m_q <= m_d;
            out_q <= out_d;
            idx_q <= idx_d;
            nops_q <= nops_d;
            err_q <= err_d;
            busy_q <= busy_d;
        end
    end
endmodule

// File: tb/tb_rsa_mont_exp_param.sv
// tb_rsa_mont_exp_param: directed and randomized checks of the exponentiator against a modexp model
module tb_rsa_mont_exp_param;
    localparam int W = 8;
    localparam int KW = $clog2(W + 1);
    typedef struct {
        logic [W-1:0] out;
        logic err;
        logic [KW:0] nops;
    } exp_t;
    logic clk = 1'b0, rst = 1'b1, i_valid = 1'b0, o_ready = 1'b1;
    logic i_ready, o_valid, o_err;
    logic [W-1:0] i_base = '0, i_msg = '0, i_key = '0, i_modulus = '0, o_out;
    logic [KW-1:0] i_key_len = '0;
    logic [KW:0] o_nops;
    int vecs = 0, errs = 0;
    bit rdy_rand = 1'b0, rdy_hold = 1'b0;
    exp_t q[$];

    always #5 clk = ~clk;

    rsa_mont_exp_param #(.WIDTH(W)) u_dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_base(i_base), .i_msg(i_msg),
        .i_key(i_key), .i_key_len(i_key_len), .i_modulus(i_modulus), .o_valid(o_valid), .o_ready(o_ready),
        .o_out(o_out), .o_err(o_err), .o_nops(o_nops)
    );

    always @(posedge clk) begin
        #1;
        o_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : !rdy_hold;
    end

    function automatic exp_t model(input int n, input int msg, input int key, input int klen);
        exp_t e;
        longint r = 1, b = msg;
        e.err = (n % 2 == 0) || (klen > W);
        if (!e.err)
            for (int i = 0; i < klen; i++) begin
                if (((key >> i) & 1) != 0) r = r * b % n;
                b = b * b % n;
            end
        e.out = e.err ? '0 : W'(r);
        e.nops = (!e.err && klen > 0) ? (KW+1)'(1 + $countones(key & ((1 << klen) - 1)) + klen - 1) : '0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        vecs++;
        errs++;
        $display("FAIL %s: bound expired, got no event, required one", name);
    endtask

    always @(negedge clk) begin
        if (!rst && o_valid) begin
            vecs++;
            if (q.size() == 0) begin
                errs++;
                $display("FAIL spurious_valid: got o_valid=1 out=%0d, required o_valid=0", o_out);
            end else if ({o_out, o_err, o_nops, i_ready} !== {q[0].out, q[0].err, q[0].nops, 1'b0}) begin
                errs++;
                $display("FAIL result: got out=%0d err=%0d nops=%0d i_ready=%0d, required out=%0d err=%0d nops=%0d i_ready=0",
                         o_out, o_err, o_nops, i_ready, q[0].out, q[0].err, q[0].nops);
            end
            if (o_ready && q.size() != 0) void'(q.pop_front());
        end
    end

    task automatic req(input int n, input int msg, input int key, input int klen);
        int t = 0;
        @(negedge clk);
        i_modulus = W'(n);
        i_msg = W'(msg);
        i_key = W'(key);
        i_key_len = KW'(klen);
        i_base = W'((n > 1) ? (65536 % n) : 0);
        i_valid = 1'b1;
        while (!i_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!i_ready) begin
            timeout("accept");
            i_valid = 1'b0;
            return;
        end
        @(posedge clk);
        q.push_back(model(n, msg, key, klen));
        #1 i_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!o_valid && lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!o_valid) timeout("o_valid");
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) timeout("drain");
    endtask

    task automatic lit(input int n, input int msg, input int key, input int klen,
                       input int eout, input int eerr, input int enops);
        exp_t e = model(n, msg, key, klen);
        chk("pin_out", 32'(e.out), eout);
        chk("pin_err", 32'(e.err), eerr);
        chk("pin_nops", 32'(e.nops), enops);
        req(n, msg, key, klen);
        drain();
    endtask

    initial begin
        int lat, t;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_i_ready", 32'(i_ready), 1);
        chk("rst_o_valid", 32'(o_valid), 0);
        chk("rst_o_out", 32'(o_out), 0);
        chk("rst_o_err", 32'(o_err), 0);
        chk("rst_o_nops", 32'(o_nops), 0);
        lit(187, 5, 3, 2, 125, 0, 4);
        lit(187, 2, 8'h80, 8, 69, 0, 9);
        lit(187, 2, 8'h00, 8, 1, 0, 8);
        lit(187, 5, 1, 1, 5, 0, 2);
        req(187, 7, 5, 0);
        wait_valid(lat);
        chk("len0_latency", 32'(lat), 2);
        drain();
        lit(186, 5, 3, 2, 0, 1, 0);
        lit(187, 5, 3, 9, 0, 1, 0);
        rdy_hold = 1'b1;
        req(187, 5, 3, 2);
        wait_valid(lat);
        repeat (20) begin
            @(negedge clk);
            chk("stall_o_valid", 32'(o_valid), 1);
        end
        rdy_hold = 1'b0;
        lit(187, 2, 8'h80, 8, 69, 0, 9);
        req(187, 5, 3, 2);
        t = 0;
        while (u_dut.state_q != rsa_mont_exp_param_pkg::MUL && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (u_dut.state_q != rsa_mont_exp_param_pkg::MUL) timeout("reach_mul");
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            chk("post_rst_i_ready", 32'(i_ready), 1);
        end
        lit(187, 5, 3, 2, 125, 0, 4);
        rdy_rand = 1'b1;
        for (int k = 0; k < 500; k++) begin
            int n, klen;
            n = ($urandom_range(0, 19) == 0) ? 2 * $urandom_range(2, 127) : 2 * $urandom_range(1, 127) + 1;
            klen = ($urandom_range(0, 19) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
            req(n, int'($urandom_range(0, n - 1)), $urandom_range(0, 255), klen);
        end
        drain();
        rdy_rand = 1'b0;
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
